// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the PC sequencer: branch opcode, funct3 codes, FSM states.
// Also holds the saturating increment used by the taken-branch counter.
package pc_sequencer_pkg;

  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] BEQ  = 3'd0;
  localparam logic [2:0] BNE  = 3'd1;
  localparam logic [2:0] BLT  = 3'd4;
  localparam logic [2:0] BGE  = 3'd5;
  localparam logic [2:0] BLTU = 3'd6;
  localparam logic [2:0] BGEU = 3'd7;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    BR_ISSUE = 3'd2,
    BR_WAIT  = 3'd3,
    ISSUE    = 3'd4,
    TRAP     = 3'd5
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_sequencer_imm_b_decode.sv
// B-type immediate extraction, sign-extended to 32 bits.
// Latency: combinational. Backpressure: none.
module imm_b_decode (
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  assign imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode sequencer: fetches at pc, issues branches to the branch unit or other ops to execute.
// Latency: 3 cycles ack-to-next-fetch for non-branch, 4 for branch; stalls in FETCH and ISSUE on ack/ready.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        br_enable,
  output logic [2:0]  br_funct3,
  output logic [31:0] br_imm,
  output logic [31:0] br_pc,
  input  logic [31:0] br_next_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        trap,
  output logic [15:0] br_taken_count
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] pc_plus4;
  logic        br_misaligned;

  assign pc_plus4      = pc + 32'd4;
  assign br_misaligned = (br_next_pc[1:0] != 2'b00);

  // ir and pc only change in FETCH/BR_WAIT/ISSUE/TRAP, so the branch
  // operands stay stable from BR_ISSUE through BR_WAIT by construction.
  assign imem_addr = pc;
  assign instr     = ir;
  assign instr_pc  = pc;
  assign br_funct3 = ir[14:12];
  assign br_pc     = pc;

  imm_b_decode u_imm_b_decode (
    .instr (ir),
    .imm   (br_imm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FETCH;
      pc             <= RESET_VECTOR;
      ir             <= '0;
      br_taken_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: begin
          if (imem_ack) ir <= imem_rdata;
        end
        BR_WAIT: begin
          if (!br_misaligned) begin
            pc <= br_next_pc;
            if (br_next_pc != pc_plus4) br_taken_count <= sat_inc16(br_taken_count);
          end
        end
        ISSUE: begin
          if (instr_ready) pc <= pc_plus4;
        end
        TRAP: begin
          pc <= TRAP_VECTOR;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    br_enable   = 1'b0;
    instr_valid = 1'b0;
    trap        = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = DECODE;
      end
      DECODE:   state_nxt = (ir[6:0] == BRANCH) ? BR_ISSUE : ISSUE;
      BR_ISSUE: begin
        br_enable = 1'b1;
        state_nxt = BR_WAIT;
      end
      BR_WAIT:  state_nxt = br_misaligned ? TRAP : FETCH;
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) state_nxt = FETCH;
      end
      TRAP: begin
        trap      = 1'b1;
        state_nxt = FETCH;
      end
      default:  state_nxt = FETCH;
    endcase
    // Outputs are forced quiet for the whole reset window, not just after the first edge.
    if (reset) begin
      state_nxt   = FETCH;
      imem_req    = 1'b0;
      br_enable   = 1'b0;
      instr_valid = 1'b0;
      trap        = 1'b0;
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, is the PC loaded on a misaligned branch target.
REQ-003 Port clk, in, 1: single clock; all state updates on posedge clk.
REQ-004 Port reset, in, 1: synchronous, active-high reset.
REQ-005 Port imem_req, out, 1: instruction fetch request, held until imem_ack.
REQ-006 Port imem_addr, out, 32: fetch address, equal to pc while imem_req is high.
REQ-007 Port imem_ack, in, 1: fetch data valid this cycle.
REQ-008 Port imem_rdata, in, 32: fetched instruction.
REQ-009 Port br_enable, out, 1: one-cycle issue pulse to the branch unit.
REQ-010 Port br_funct3, out, 3: instr[14:12] of the branch.
REQ-011 Port br_imm, out, 32: sign-extended B-immediate {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
REQ-012 Port br_pc, out, 32: PC of the branch.
REQ-013 Port br_next_pc, in, 32: registered branch-unit result, valid the cycle after br_enable.
REQ-014 Port instr_valid, out, 1: non-branch instruction offered to execute.
REQ-015 Port instr, out, 32 and instr_pc, out, 32: offered instruction and its PC.
REQ-016 Port instr_ready, in, 1: execute accepts the offered instruction.
REQ-017 Port trap, out, 1: one-cycle pulse on misaligned branch target.
REQ-018 Port br_taken_count, out, 16: count of taken branches.

Function
REQ-019 States SHALL be FETCH, DECODE, BR_ISSUE, BR_WAIT, ISSUE, TRAP.
REQ-020 FETCH: imem_req=1, imem_addr=pc; on imem_ack capture imem_rdata into ir and go to DECODE; otherwise stay.
REQ-021 DECODE: ir[6:0]==7'b1100011 goes to BR_ISSUE; any other opcode goes to ISSUE.
REQ-022 BR_ISSUE: br_enable=1 for exactly one cycle with br_funct3/br_imm/br_pc driven from ir and pc, then BR_WAIT.
REQ-023 br_funct3/br_imm/br_pc SHALL remain stable from BR_ISSUE through BR_WAIT.
REQ-024 BR_WAIT: sample br_next_pc; if br_next_pc[1:0]!=0 go to TRAP, else pc<=br_next_pc and go to FETCH.
REQ-025 Taken branch means br_next_pc != pc+4; on a taken, aligned branch br_taken_count increments, saturating at 16'hFFFF.
REQ-026 Reserved funct3 (2,3) SHALL NOT be special-cased; whatever br_next_pc returns is used.
REQ-027 ISSUE: instr_valid=1, instr=ir, instr_pc=pc, held stable until instr_ready; on handshake pc<=pc+4, go to FETCH.
REQ-028 TRAP: trap=1 for one cycle, pc<=TRAP_VECTOR, then FETCH; br_taken_count unchanged.
REQ-029 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-030 Minimum latency: non-branch 3 cycles fetch-ack to next imem_req (with instr_ready high); branch 4 cycles.
REQ-031 imem_req, br_enable, instr_valid and trap SHALL be mutually exclusive in every cycle.

Reset
REQ-032 While reset is high: state=FETCH, pc=RESET_VECTOR, ir=0, br_taken_count=0, imem_req=0, br_enable=0, instr_valid=0, trap=0; reset has priority over every transition.
REQ-033 Reset mid-operation (any state, incl. pending imem_ack or instr_ready) SHALL discard the in-flight instruction; imem_req rises the first cycle after reset deasserts.

Structure
REQ-034 A shared package holds the opcode constant BRANCH=7'b1100011, the funct3 codes BEQ/BNE/BLT/BGE/BLTU/BGEU, and the state encoding.
REQ-035 B-immediate extraction is a sub-module, imm_b_decode, combinational, 32-bit in/out.

Verification
REQ-036 Reset, fetch 32'h00000013 (addi) with instr_ready=1 -> instr_valid one cycle, next imem_addr=32'h4.
REQ-037 At pc=32'h10 fetch beq imm=+8, br_next_pc=32'h18 -> br_enable one pulse, br_imm=32'h8, next imem_addr=32'h18, br_taken_count=1.
REQ-038 Branch with br_next_pc=32'h1A -> trap one cycle, next imem_addr=32'h100, count unchanged.
REQ-039 instr_ready low for 5 cycles -> instr/instr_pc stable, pc unchanged, no imem_req until accept.
REQ-040 pc=32'hFFFFFFFC non-branch accepted -> next imem_addr=32'h0; count preloaded 16'hFFFF plus taken branch -> stays 16'hFFFF.
REQ-041 Reset asserted in BR_WAIT -> no pc update from br_next_pc, imem_addr=RESET_VECTOR after release.
